// File: rtl/ssd_scan_ctrl.sv
// Purpose : time-multiplexed 4-digit seven-segment scanner (estado + sensor bank), with blanking and alarm blink.
// Latency : SSD is registered; it reflects prescaler/digit/snapshot state one cycle earlier.
// Backpr. : none; en=0 freezes scan state and blanks the display on the next cycle.
//
// Ports:
//   CLK_ulong  rising-edge clock          reset      async active-low reset
//   en         scan enable                estado     alarm-FSM state code (0-7)
//   sensores   raw sensor lines           SSD        {anodes[3:0], segments gfedcba}, both active-low
//   digit_idx  digit being scanned        slot_tick  pulse on the last cycle of each slot
//
// Optional build macro SENSOR_SYNC_EN: routes sensores through a two-flop
// synchronizer ahead of the frame snapshot register.
module ssd_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16,
    parameter int BLINK_DIV = 64
) (
    input  logic        CLK_ulong,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  estado,
    input  logic [3:0]  sensores,
    output logic [10:0] SSD,
    output logic [1:0]  digit_idx,
    output logic        slot_tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [6:0]    SEG_DASH   = 7'h3F;
    localparam logic [10:0]   SSD_OFF    = 11'h7FF;

    function automatic logic [6:0] seg_of(input logic [2:0] d);
        logic [6:0] s;
        s = 7'h7F;
        case (d)
            3'd0: s = 7'h40;
            3'd1: s = 7'h79;
            3'd2: s = 7'h24;
            3'd3: s = 7'h30;
            3'd4: s = 7'h19;
            3'd5: s = 7'h12;
            3'd6: s = 7'h02;
            3'd7: s = 7'h78;
        endcase
        return s;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          bphase_off_q, bphase_off_d;
    logic [3:0]    snap_q, snap_d;
    logic [2:0]    est_snap_q, est_snap_d;
    logic [10:0]   ssd_q, ssd_d;

    logic          tick;
    logic          blink_active;
    logic [3:0]    sens_cap;
    logic [2:0]    popcnt;
    logic [2:0]    low_idx;
    logic [6:0]    seg_val;

`ifdef SENSOR_SYNC_EN
    logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = sensores;
        sync2_d = sync1_q;
    end

    // Synchronizer runs regardless of en so the capture setup stays two cycles.
    always_ff @(posedge CLK_ulong or negedge reset) begin
        if (!reset) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sens_cap = sync2_q;
`else
    assign sens_cap = sensores;
`endif

    assign tick         = en && (presc_q == PRESC_LAST);
    assign blink_active = (est_snap_q >= 3'd4);

    // Digit content is derived purely from the frame snapshot.
    always_comb begin
        popcnt  = 3'($countones(snap_q));
        low_idx = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (snap_q[i]) low_idx = 3'(i);
        end
        seg_val = SEG_DASH;
        case (digit_q)
            2'd3:    seg_val = seg_of(est_snap_q);
            2'd2:    seg_val = SEG_DASH;
            2'd1:    seg_val = seg_of(popcnt);
            default: if (snap_q != 4'd0) seg_val = seg_of(low_idx);
        endcase
    end

    always_comb begin
        presc_d      = presc_q;
        digit_d      = digit_q;
        bcnt_d       = bcnt_q;
        bphase_off_d = bphase_off_q;
        snap_d       = snap_q;
        est_snap_d   = est_snap_q;

        if (en) presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        if (tick) digit_d = digit_q + 2'd1;

        // Blink state keys off the current snapshot; a frame start on the same
        // edge only changes blink activity from the following cycle.
        if (!blink_active) begin
            bcnt_d       = '0;
            bphase_off_d = 1'b0;
        end else if (tick) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d       = '0;
                bphase_off_d = ~bphase_off_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end

        if (tick && digit_q == 2'd3) begin
            snap_d     = sens_cap;
            est_snap_d = estado;
        end

        if (!en || presc_q < BLANK_END || (blink_active && bphase_off_q))
            ssd_d = SSD_OFF;
        else
            ssd_d = {~(4'b0001 << digit_q), seg_val};
    end

    always_ff @(posedge CLK_ulong or negedge reset) begin
        if (!reset) begin
            presc_q      <= '0;
            digit_q      <= 2'd0;
            bcnt_q       <= '0;
            bphase_off_q <= 1'b0;
            snap_q       <= 4'd0;
            est_snap_q   <= 3'd0;
            ssd_q        <= SSD_OFF;
        end else begin
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            bcnt_q       <= bcnt_d;
            bphase_off_q <= bphase_off_d;
            snap_q       <= snap_d;
            est_snap_q   <= est_snap_d;
            ssd_q        <= ssd_d;
        end
    end

    assign SSD       = ssd_q;
    assign digit_idx = digit_q;
    assign slot_tick = tick;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Purpose : randomized + directed bench for ssd_scan_ctrl against a cycle-level behavioural model.
// Latency : model predicts the registered SSD one cycle after the state it depends on.
// Backpr. : none; en toggling is part of the stimulus.
module tb_ssd_scan_ctrl;

    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int BLINK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  estado = 3'd0;
    logic [3:0]  sensores = 4'd0;
    logic [10:0] ssd;
    logic [1:0]  digit_idx;
    logic        slot_tick;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int          m_presc;
    int          m_digit;
    int          m_bslots;   // slot ticks seen since blinking became active
    logic [3:0]  m_snap;
    logic [2:0]  m_est;
    logic [10:0] m_ssd;
    logic [3:0]  sh1, sh2;   // sensor history for the synchronized build

    always #5 clk = ~clk;

    ssd_scan_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .BLANK_CYC(BLANK_CYC),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .CLK_ulong(clk),
        .reset    (rst_n),
        .en       (en),
        .estado   (estado),
        .sensores (sensores),
        .SSD      (ssd),
        .digit_idx(digit_idx),
        .slot_tick(slot_tick)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_code(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            default: return 7'h7F;
        endcase
    endfunction

    // What the display should show for a given scan position and snapshot.
    function automatic logic [10:0] disp(input int presc, input int digit, input logic [3:0] snap,
                                         input logic [2:0] est, input int bslots, input logic en_v);
        logic [6:0] s;
        logic [3:0] an;
        if (!en_v || presc < BLANK_CYC) return 11'h7FF;
        if (est >= 4 && ((bslots / BLINK_DIV) % 2) == 1) return 11'h7FF;
        s = 7'h3F;
        if (digit == 3) s = seg_code(int'(est));
        else if (digit == 1) s = seg_code($countones(snap));
        else if (digit == 0 && snap != 4'd0) begin
            for (int i = 3; i >= 0; i--) if (snap[i]) s = seg_code(i);
        end
        an = 4'b0001 << digit;
        return {~an, s};
    endfunction

    task automatic model_reset();
        m_presc = 0; m_digit = 0; m_bslots = 0;
        m_snap = 4'd0; m_est = 3'd0; m_ssd = 11'h7FF;
        sh1 = 4'd0; sh2 = 4'd0;
    endtask

    task automatic model_edge();
        logic [10:0] nssd;
        logic [3:0]  eff;
        bit          tick;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick = en && (m_presc == CLK_DIV - 1);
        nssd = disp(m_presc, m_digit, m_snap, m_est, m_bslots, en);
`ifdef SENSOR_SYNC_EN
        eff = sh2; sh2 = sh1; sh1 = sensores;
`else
        eff = sensores;
`endif
        if (m_est < 4) m_bslots = 0;
        else if (tick) m_bslots++;
        if (tick && m_digit == 3) begin
            m_snap = eff;
            m_est  = estado;
        end
        if (en) m_presc = (m_presc + 1) % CLK_DIV;
        if (tick) m_digit = (m_digit + 1) % 4;
        m_ssd = nssd;
    endtask

    task automatic compare();
        chk_val("ssd", 32'(ssd), 32'(m_ssd));
        chk_val("digit_idx", 32'(digit_idx), 32'(m_digit));
        chk_val("slot_tick", 32'(slot_tick), 32'(en && (m_presc == CLK_DIV - 1)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_for(input int p, input int d);
        bit found = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_presc == p && (d < 0 || m_digit == d)) begin
                found = 1;
                break;
            end
            cycle();
        end
        chk_val("wait_reached", 32'(found), 32'd1);
    endtask

    initial begin
        model_reset();

        // Reset held, then released with en=0
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();

        // estado=2, no sensors, two frames
        estado = 3'd2; sensores = 4'd0; en = 1'b1;
        repeat (40) cycle();
        wait_for(5, 3);
        chk_val("digit3_est2", 32'(ssd), 32'h3A4);

        // Mid-frame sensor change shows only in the next frame
        sensores = 4'b0110;
        wait_for(5, 0);
        chk_val("digit0_idx1", 32'(ssd), 32'h779);
        wait_for(5, 1);
        chk_val("digit1_cnt2", 32'(ssd), 32'h6A4);

        // Blinking with estado >= 4, then back to steady
        estado = 3'd5;
        repeat (4 * 4 * CLK_DIV) cycle();
        estado = 3'd2;
        repeat (3 * 4 * CLK_DIV) cycle();

        // en dropped at prescaler 5
        wait_for(5, -1);
        en = 1'b0;
        repeat (10) cycle();
        en = 1'b1;
        cycle();
        cycle();
        chk_val("tick_after_resume", 32'(slot_tick), 32'd1);

        // Capture setup at frame start
        sensores = 4'd0;
        repeat (4 * CLK_DIV) cycle();
`ifdef SENSOR_SYNC_EN
        wait_for(7, 3);
        sensores = 4'b0010;
        wait_for(5, 0);
        chk_val("sync_late_not_captured", 32'(ssd), 32'h73F);
        sensores = 4'd0;
        wait_for(7, 3);
        wait_for(5, 0);
        wait_for(5, 3);
        sensores = 4'b0010;
        wait_for(5, 0);
        chk_val("sync_early_captured", 32'(ssd), 32'h779);
`else
        wait_for(7, 3);
        sensores = 4'b0010;
        wait_for(5, 0);
        chk_val("direct_capture", 32'(ssd), 32'h779);
`endif

        // Randomized operation
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) estado = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) sensores = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 9) != 0);
            cycle();
        end

        // Asynchronous reset mid-slot
        en = 1'b1;
        estado = 3'd6;
        sensores = 4'b1000;
        wait_for(4, -1);
        #1 rst_n = 1'b0;
        #1;
        chk_val("async_ssd", 32'(ssd), 32'h7FF);
        chk_val("async_digit", 32'(digit_idx), 32'd0);
        chk_val("async_tick", 32'(slot_tick), 32'd0);
        model_reset();
        repeat (3) cycle();
        rst_n = 1'b1;
        wait_for(5, 3);
        chk_val("post_reset_digit3_zero", 32'(ssd), 32'h3C0);
        repeat (3 * 4 * CLK_DIV) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
